// File: rtl/d74l138_pkg.sv
// ============================================================================
// Module   : d74l138_pkg
// Brief    : Shared widths and idle output value for the 3-to-8 decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package d74l138_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    localparam logic [OUT_W-1:0] Y_IDLE = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/d74l138_core.sv
// ============================================================================
// Module   : d74l138_core
// Brief    : Combinational decode of enables and select into the next Y.
// Revision : 1.0
// ============================================================================
`default_nettype none

module d74l138_core
    import d74l138_pkg::*;
(
    input  logic             g_i,
    input  logic             g2a_i,
    input  logic             g2b_i,
    input  logic [SEL_W-1:0] idx_i,
    output logic [OUT_W-1:0] y_o
);

    logic w_enabled;

    assign w_enabled = g_i && !g2a_i && !g2b_i;

    // Outputs are active-low: only the selected line drops, and only when enabled.
    always_comb begin
        y_o = Y_IDLE;
        if (w_enabled) begin
            y_o[idx_i] = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/d74l138.sv
// ============================================================================
// Module   : d74l138
// Brief    : Registered 3-to-8 active-low decoder with three-input enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module d74l138
    import d74l138_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             G,
    input  logic             G2A,
    input  logic             G2B,
    input  logic             C,
    input  logic             B,
    input  logic             A,
    output logic [OUT_W-1:0] Y
);

    logic [SEL_W-1:0] w_idx;
    logic [OUT_W-1:0] y_d;
    logic [OUT_W-1:0] y_q;

    assign w_idx = {C, B, A};

    d74l138_core u_core (
        .g_i   (G),
        .g2a_i (G2A),
        .g2b_i (G2B),
        .idx_i (w_idx),
        .y_o   (y_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= Y_IDLE;
        end else begin
            y_q <= y_d;
        end
    end

    assign Y = y_q;

endmodule

`default_nettype wire

// File: tb/tb_d74l138.sv
// ============================================================================
// Module   : tb_d74l138
// Brief    : Scoreboard bench for d74l138 with random and directed stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_d74l138;

    logic       clk;
    logic       rst_n;
    logic       G, G2A, G2B, C, B, A;
    logic [7:0] Y;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    d74l138 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .G     (G),
        .G2A   (G2A),
        .G2B   (G2B),
        .C     (C),
        .B     (B),
        .A     (A),
        .Y     (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic g, input logic g2a,
                                         input logic g2b, input int idx);
        int v;
        if (g && !g2a && !g2b) v = 255 - (1 << idx);
        else                   v = 255;
        return v[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: Y=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic g, input logic g2a, input logic g2b, input int idx);
        logic [2:0] s;
        s   = idx[2:0];
        G   = g;
        G2A = g2a;
        G2B = g2b;
        C   = s[2];
        B   = s[1];
        A   = s[0];
    endtask

    // One stimulus per cycle, applied away from the edge; expectation queued.
    task automatic step(input logic g, input logic g2a, input logic g2b, input int idx);
        @(posedge clk);
        #2;
        set_inputs(g, g2a, g2b, idx);
        exp_q.push_back(model(g, g2a, g2b, idx));
    endtask

    task automatic step_random();
        step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 7));
    endtask

    // Monitor: the DUT presents a new Y every edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", Y, e);
            end
        end
    end

    // Invariant: at most one low bit, none if the last sample was disabled.
    initial begin
        logic prev_en;
        int   zeros;
        forever begin
            @(posedge clk);
            prev_en = rst_n && G && !G2A && !G2B;
            #1;
            zeros = $countones(~Y);
            checks++;
            if (zeros > 1 || (!prev_en && zeros != 0)) begin
                errors++;
                $display("FAIL invariant: Y=%h zeros=%0d prev_enabled=%0b", Y, zeros, prev_en);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        set_inputs(1'b1, 1'b0, 1'b0, 3);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_async", Y, 8'hFF);

        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", Y, 8'hFF);
        end

        @(posedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.push_back(model(1'b1, 1'b0, 1'b0, 3));

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, i);

        step(1'b0, 1'b0, 1'b0, 5);
        step(1'b1, 1'b0, 1'b1, 2);
        step(1'b1, 1'b1, 1'b0, 6);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, i);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 7);

        for (int i = 0; i < 150; i++) step_random();

        step(1'b1, 1'b0, 1'b0, 7);
        @(posedge clk);
        #3;
        check("pre_reset_7F", Y, 8'h7F);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midop_reset_async", Y, 8'hFF);
        repeat (2) begin
            @(posedge clk);
            #2;
            set_inputs(1'b1, 1'b0, 1'b0, $urandom_range(0, 7));
            #1;
            check("midop_reset_hold", Y, 8'hFF);
        end

        @(posedge clk);
        #2;
        rst_n = 1'b1;
        set_inputs(1'b1, 1'b0, 1'b0, 4);
        exp_q.push_back(model(1'b1, 1'b0, 1'b0, 4));
        for (int i = 0; i < 50; i++) step_random();

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
